// File: rtl/conv_sched_pkg.sv
// Shared types and elaboration-time helpers for the convolution window scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } sched_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned k,
                                          input int unsigned stride);
        return (img_w - k) / stride + 1;
    endfunction

    function automatic int unsigned out_h(input int unsigned img_h, input int unsigned k,
                                          input int unsigned stride);
        return (img_h - k) / stride + 1;
    endfunction

    function automatic int unsigned taps(input int unsigned k);
        return k * k;
    endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// Buffer/MAC side bus of the window scheduler: tap reads, MAC handshake, output writes.
interface conv_window_sched_if #(
    parameter int unsigned FM_AW  = 10,
    parameter int unsigned W_AW   = 5,
    parameter int unsigned OUT_AW = 10,
    parameter int unsigned ACC_W  = 38
) ();
    logic              fm_rd_en;
    logic [FM_AW-1:0]  fm_rd_addr;
    logic [W_AW-1:0]   w_rd_addr;
    logic              mac_start;
    logic              mac_ready;
    logic [ACC_W-1:0]  mac_data;
    logic              out_wr_en;
    logic [OUT_AW-1:0] out_wr_addr;
    logic [ACC_W-1:0]  out_wr_data;

    modport master (
        output fm_rd_en, fm_rd_addr, w_rd_addr, mac_start,
        output out_wr_en, out_wr_addr, out_wr_data,
        input  mac_ready, mac_data
    );

    modport slave (
        input  fm_rd_en, fm_rd_addr, w_rd_addr, mac_start,
        input  out_wr_en, out_wr_addr, out_wr_data,
        output mac_ready, mac_data
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Window/tap position counters with incremental feature-map, weight and output addressing.
module conv_addr_gen
    import conv_sched_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned K      = 5,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned FM_AW  = 10,
    parameter int unsigned W_AW   = 5,
    parameter int unsigned OUT_AW = 10
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              tap_step,
    input  logic              pos_step,
    output logic [FM_AW-1:0]  fm_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [OUT_AW-1:0] out_addr,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_pos
);
    localparam int unsigned OW = out_w(IMG_W, K, STRIDE);
    localparam int unsigned OH = out_h(IMG_H, K, STRIDE);
    localparam int unsigned CW = clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);

    localparam logic [FM_AW-1:0] ROW_STEP  = FM_AW'(IMG_W);
    localparam logic [FM_AW-1:0] COL_STEP  = FM_AW'(STRIDE);
    localparam logic [FM_AW-1:0] LINE_STEP = FM_AW'(STRIDE * IMG_W);

    logic [CW-1:0]     kx, ky, ox, oy;
    logic [FM_AW-1:0]  line_base, win_base, row_base;
    logic [W_AW-1:0]   tap_idx;
    logic [OUT_AW-1:0] out_idx;
    logic              kx_last, ky_last, ox_last, oy_last;

    assign kx_last   = (kx == CW'(K - 1));
    assign ky_last   = (ky == CW'(K - 1));
    assign ox_last   = (ox == CW'(OW - 1));
    assign oy_last   = (oy == CW'(OH - 1));
    assign first_tap = (kx == '0) && (ky == '0);
    assign last_tap  = kx_last && ky_last;
    assign last_pos  = ox_last && oy_last;
    assign fm_addr   = row_base + FM_AW'(kx);
    assign w_addr    = tap_idx;
    assign out_addr  = out_idx;

    // line_base = top row of the current window row, win_base = window origin,
    // row_base = start of the kernel row ky inside the window.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n || clear) begin
            kx <= '0; ky <= '0; ox <= '0; oy <= '0;
            line_base <= '0; win_base <= '0; row_base <= '0;
            tap_idx <= '0; out_idx <= '0;
        end else if (tap_step) begin
            if (kx_last) begin
                kx <= '0;
                if (ky_last) begin
                    ky       <= '0;
                    tap_idx  <= '0;
                    row_base <= win_base;
                end else begin
                    ky       <= ky + CW'(1);
                    tap_idx  <= tap_idx + W_AW'(1);
                    row_base <= row_base + ROW_STEP;
                end
            end else begin
                kx      <= kx + CW'(1);
                tap_idx <= tap_idx + W_AW'(1);
            end
        end else if (pos_step) begin
            out_idx <= out_idx + OUT_AW'(1);
            if (ox_last) begin
                ox        <= '0;
                oy        <= oy + CW'(1);
                line_base <= line_base + LINE_STEP;
                win_base  <= line_base + LINE_STEP;
                row_base  <= line_base + LINE_STEP;
            end else begin
                ox       <= ox + CW'(1);
                win_base <= win_base + COL_STEP;
                row_base <= win_base + COL_STEP;
            end
        end
    end
endmodule

// File: rtl/conv_window_sched.sv
// Frame sequencer for the serial convolution MAC; optional MAC watchdog under CONV_SCHED_WDOG_EN.
module conv_window_sched
    import conv_sched_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned K      = 5,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned FM_AW  = 10,
    parameter int unsigned W_AW   = 5,
    parameter int unsigned OUT_AW = 10,
    parameter int unsigned ACC_W  = 38
`ifdef CONV_SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC = 64
`endif
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                frame_start,
    conv_window_sched_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);
    sched_state_e      state, state_next;
    logic              clear, tap_step, pos_step, capture, wdog_fire, wdog_hit;
    logic [FM_AW-1:0]  fm_addr;
    logic [W_AW-1:0]   w_addr;
    logic [OUT_AW-1:0] out_addr;
    logic              first_tap, last_tap, last_pos;

    conv_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .STRIDE(STRIDE),
        .FM_AW (FM_AW),
        .W_AW  (W_AW),
        .OUT_AW(OUT_AW)
    ) u_addr_gen (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear    (clear),
        .tap_step (tap_step),
        .pos_step (pos_step),
        .fm_addr  (fm_addr),
        .w_addr   (w_addr),
        .out_addr (out_addr),
        .first_tap(first_tap),
        .last_tap (last_tap),
        .last_pos (last_pos)
    );

`ifdef CONV_SCHED_WDOG_EN
    localparam int unsigned WDW = clog2(WDOG_CYC + 1);
    logic [WDW-1:0] wdog_cnt;

    assign wdog_hit = (state == ST_WAIT) && (wdog_cnt == WDW'(WDOG_CYC - 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            wdog_cnt <= '0;
        else if (state == ST_WAIT && !bus.mac_ready)
            wdog_cnt <= wdog_cnt + WDW'(1);
        else
            wdog_cnt <= '0;
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        tap_step   = 1'b0;
        pos_step   = 1'b0;
        capture    = 1'b0;
        wdog_fire  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    clear      = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tap_step = 1'b1;
                if (last_tap) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mac_ready) begin
                    capture    = 1'b1;
                    state_next = ST_WRITE;
                end else if (wdog_hit) begin
                    wdog_fire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                pos_step   = 1'b1;
                state_next = last_pos ? ST_DONE : ST_ISSUE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes trail the state by one cycle so every tap/write output comes straight off a flop;
    // busy uses the next state so it is high exactly while the FSM is out of IDLE.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bus.fm_rd_en    <= 1'b0;
            bus.fm_rd_addr  <= '0;
            bus.w_rd_addr   <= '0;
            bus.mac_start   <= 1'b0;
            bus.out_wr_en   <= 1'b0;
            bus.out_wr_addr <= '0;
            bus.out_wr_data <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            err             <= 1'b0;
        end else begin
            bus.fm_rd_en  <= (state == ST_ISSUE);
            bus.mac_start <= (state == ST_ISSUE) && first_tap;
            if (state == ST_ISSUE) begin
                bus.fm_rd_addr <= fm_addr;
                bus.w_rd_addr  <= w_addr;
            end
            bus.out_wr_en <= (state == ST_WRITE);
            if (state == ST_WRITE) bus.out_wr_addr <= out_addr;
            if (capture)           bus.out_wr_data <= bus.mac_data;
            busy       <= (state_next != ST_IDLE);
            frame_done <= (state == ST_DONE);
            err        <= wdog_fire;
        end
    end
endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
Sequencing controller for the serial convolution MAC (K*K data/weight pairs per output, result plus bias returned with a 1-cycle ready pulse).
- Per frame, walks every valid output position of an IMG_W x IMG_H feature map.
- For each position it issues K*K feature-map and weight read addresses on consecutive cycles and pulses the MAC start.
- It waits for the MAC ready pulse, then writes the result to the output-map buffer at the linear output address.
- Sits between the frame-level layer control and the feature/weight/output buffers.

Parameters:
IMG_W, 28, input map width in pixels
IMG_H, 28, input map height in pixels
K, 5, kernel side; taps per output = K*K (matches MAC filter_size)
STRIDE, 1, window step in x and y (>=1)
FM_AW, 10, feature-map read address width
W_AW, 5, weight read address width
OUT_AW, 10, output-map write address width
ACC_W, 38, MAC result width (2*BITS+clog2(K*K)+1 for BITS=16)

Ports:
clk_in  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  1-cycle pulse; begins a frame when idle
fm_rd_en  out  1  feature/weight read strobe, high during tap issue
fm_rd_addr  out  FM_AW  feature-map pixel address for current tap
w_rd_addr  out  W_AW  weight address = tap index ky*K+kx
mac_start  out  1  1-cycle pulse on the cycle tap 0 is issued
mac_ready  in  1  MAC result-valid pulse
mac_data  in  ACC_W  MAC result (signed), valid with mac_ready
out_wr_en  out  1  output buffer write strobe
out_wr_addr  out  OUT_AW  oy*OW+ox
out_wr_data  out  ACC_W  registered mac_data
busy  out  1  high in any state except IDLE
frame_done  out  1  1-cycle pulse after the last write of a frame
err  out  1  watchdog error pulse (feature-gated)

Behaviour:
- Clock clk_in; reset rst_n asynchronous, active-low.
- Reset value of every output is 0, state IDLE, all counters 0.
- Reset mid-frame aborts with no further writes.
- Derived constants: OW=(IMG_W-K)/STRIDE+1, OH=(IMG_H-K)/STRIDE+1, TAPS=K*K.
- Counters: ox, oy (output position); kx, ky (tap).
- Pixel address: fm_rd_addr = (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx.
  - Computed incrementally via registered row base and window base; no per-tap multiplier.
- All outputs are registered.
- FSM states:
  - IDLE: a frame_start pulse goes to ISSUE with ox=oy=kx=ky=0. frame_start is ignored in every other state (no queueing).
  - ISSUE: fm_rd_en=1 for exactly TAPS consecutive cycles.
    - mac_start=1 only on the tap-0 cycle.
    - kx wraps at K-1 and increments ky.
    - After tap TAPS-1, go to WAIT.
  - WAIT: hold addresses and deassert fm_rd_en.
    - On mac_ready, capture mac_data into out_wr_data and go to WRITE.
    - mac_ready seen in any state other than WAIT is ignored.
  - WRITE: out_wr_en=1 for one cycle at out_wr_addr=oy*OW+ox.
    - Advance ox; ox wraps at OW-1 and increments oy.
    - If ox=OW-1 and oy=OH-1, go to DONE; else go to ISSUE.
    - WRITE guarantees at least one cycle between MAC ready and the next mac_start.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Latency per output = TAPS + MAC latency + 2 cycles. frame_done follows the final out_wr_en by 1 cycle.
- Simultaneous frame_start and DONE: frame_start is ignored.

Optional Feature:
CONV_SCHED_WDOG_EN
- Defined: adds parameter WDOG_CYC (default 64) and a counter that runs in WAIT.
  - If mac_ready is absent for WDOG_CYC cycles, pulse err for 1 cycle, return to IDLE without writing, and do not pulse frame_done.
- Undefined: WAIT holds indefinitely and err is tied to 0.

Decomposition:
- Package conv_sched_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, WRITE, DONE).
  - Functions computing OW, OH, TAPS.
  - clog2 helper.
- One sub-module, conv_addr_gen:
  - Owns the ox/oy/kx/ky counters and incremental fm/w/out address arithmetic.
  - Controlled by tap_step, pos_step and clear inputs.
  - Outputs last_tap and last_pos flags.

Test Plan:
- IMG 6x6, K=3, STRIDE=1, MAC model ready 4 cycles after last tap:
  - output 0 fm addrs 0,1,2,6,7,8,12,13,14 with w addrs 0..8 and mac_start on first only.
  - 16 writes at addrs 0..15.
  - frame_done once.
- Same config, output (oy=1, ox=2): fm addrs 8,9,10,14,15,16,20,21,22; out_wr_addr=6; out_wr_data equals mac_data captured (e.g. -1234).
- IMG 7x7, K=3, STRIDE=2: OW=OH=3. Output index 4 window base 16 (16,17,18,23,24,25,30,31,32). 9 writes total.
- frame_start pulsed during ISSUE and again during DONE -> ignored; exactly one frame_done; busy low only after DONE.
- rst_n asserted mid-WAIT at output 5 -> all outputs 0 next edge; no out_wr_en. A new frame_start restarts at output 0.
- With CONV_SCHED_WDOG_EN, WDOG_CYC=8, MAC never responds -> err pulse 8 cycles into WAIT, state IDLE, no frame_done. Without the macro: busy stays high and err stays 0.
